// File: rtl/quidditch_ball_controller_if.sv
// Player-position inputs and ball/score outputs of quidditch_ball_controller.
// master drives player rows and observes the ball; slave is the controller.
interface quidditch_ball_controller_if;
  logic [9:0] team1_ver_position;
  logic [9:0] team2_ver_position;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] team1_score;
  logic [3:0] team2_score;
  logic       goal_flash;
  logic       game_over;

  modport master (
    output team1_ver_position, team2_ver_position,
    input  ball_x, ball_y, team1_score, team2_score, goal_flash, game_over
  );

  modport slave (
    input  team1_ver_position, team2_ver_position,
    output ball_x, ball_y, team1_score, team2_score, goal_flash, game_over
  );
endinterface

// File: rtl/quidditch_ball_controller.sv
// Quaffle controller: serve/play/goal/over sequencing, ball motion, scoring.
// Optional BALL_SPEEDUP_EN halves the move period on every 4th player hit.
module quidditch_ball_controller #(
  parameter int PLAYER_RADIUS           = 25,
  parameter int BALL_RADIUS             = 5,
  parameter int GOAL_RADIUS             = 40,
  parameter int GOAL_CENTER_Y           = 300,
  parameter int TEAM1_HOR_POS           = 300,
  parameter int TEAM2_HOR_POS           = 700,
  parameter int FIELD_MIN_X             = 20,
  parameter int FIELD_MAX_X             = 780,
  parameter int FIELD_MIN_Y             = 20,
  parameter int FIELD_MAX_Y             = 580,
  parameter int INITIAL_BALL_X          = 500,
  parameter int INITIAL_BALL_Y          = 300,
  parameter int BALL_MOVEMENT_FREQUENCY = 100000,
  parameter int SERVE_DELAY             = 64,
  parameter int GOAL_HOLD               = 128,
  parameter int WIN_SCORE               = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  quidditch_ball_controller_if.slave    bus
);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_GOAL, S_OVER} state_t;

  localparam int CNT_W = $clog2(BALL_MOVEMENT_FREQUENCY + 1);
  localparam int PH_W  = 16;

  localparam logic [9:0]  INIT_X    = 10'(INITIAL_BALL_X);
  localparam logic [9:0]  INIT_Y    = 10'(INITIAL_BALL_Y);
  localparam logic [9:0]  T1_HIT_X  = 10'(TEAM1_HOR_POS + PLAYER_RADIUS + BALL_RADIUS);
  localparam logic [9:0]  T2_HIT_X  = 10'(TEAM2_HOR_POS - PLAYER_RADIUS - BALL_RADIUS);
  localparam logic [10:0] HIT_ZONE  = 11'(PLAYER_RADIUS + BALL_RADIUS);
  localparam logic [10:0] GOAL_ZONE = 11'(GOAL_RADIUS);
  localparam logic [10:0] LIM_MAX_X = 11'(FIELD_MAX_X - BALL_RADIUS);
  localparam logic [10:0] LIM_MIN_X = 11'(FIELD_MIN_X + BALL_RADIUS);
  localparam logic [10:0] LIM_MAX_Y = 11'(FIELD_MAX_Y - BALL_RADIUS);
  localparam logic [10:0] LIM_MIN_Y = 11'(FIELD_MIN_Y + BALL_RADIUS);
  localparam logic [PH_W-1:0] SERVE_LAST = PH_W'(SERVE_DELAY - 1);
  localparam logic [PH_W-1:0] GOAL_LAST  = PH_W'(GOAL_HOLD - 1);
  localparam logic [3:0]  WIN = 4'(WIN_SCORE);

  function automatic logic [10:0] absdiff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[10] ? 11'(-d) : 11'(d);
  endfunction

  state_t          r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [PH_W-1:0] r_phase, w_phase_nxt;
  logic [9:0]      r_x, r_y, w_x_nxt, w_y_nxt;
  logic            r_dx_neg, r_dy_neg, w_dx_neg_nxt, w_dy_neg_nxt;
  logic            r_srv_dx_neg, w_srv_dx_neg_nxt;
  logic [3:0]      r_s1, r_s2, w_s1_nxt, w_s2_nxt;
  logic            r_goal_flash, r_game_over;
  logic            w_tick, w_t1_hit, w_t2_hit, w_in_goal;
  logic [10:0]     w_x_ext, w_y_ext;

  assign w_x_ext = {1'b0, r_x};
  assign w_y_ext = {1'b0, r_y};

  assign w_t1_hit  = r_dx_neg  && (r_x == T1_HIT_X) &&
                     (absdiff(r_y, bus.team1_ver_position) <= HIT_ZONE);
  assign w_t2_hit  = !r_dx_neg && (r_x == T2_HIT_X) &&
                     (absdiff(r_y, bus.team2_ver_position) <= HIT_ZONE);
  assign w_in_goal = absdiff(r_y, 10'(GOAL_CENTER_Y)) <= GOAL_ZONE;

`ifdef BALL_SPEEDUP_EN
  localparam logic [CNT_W-1:0] PERIOD_FULL = CNT_W'(BALL_MOVEMENT_FREQUENCY);
  localparam logic [CNT_W-1:0] PERIOD_MIN  =
    CNT_W'((BALL_MOVEMENT_FREQUENCY / 4 > 0) ? BALL_MOVEMENT_FREQUENCY / 4 : 1);

  logic [CNT_W-1:0] r_period, w_period_half;
  logic [1:0]       r_hits;
  logic             w_hit, w_serve_entry;

  // >= rather than == so a period shrink never strands the counter above the wrap point
  assign w_tick        = (r_state != S_OVER) && (r_cnt >= r_period - CNT_W'(1));
  assign w_hit         = w_tick && (r_state == S_PLAY) && (w_t1_hit || w_t2_hit);
  assign w_serve_entry = w_tick && (r_state == S_GOAL) && (w_state_nxt == S_SERVE);
  assign w_period_half = r_period >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= PERIOD_FULL;
      r_hits   <= '0;
    end else if (w_serve_entry) begin
      r_period <= PERIOD_FULL;
      r_hits   <= '0;
    end else if (w_hit) begin
      r_hits <= r_hits + 2'd1;
      if (r_hits == 2'd3)
        r_period <= (w_period_half < PERIOD_MIN) ? PERIOD_MIN : w_period_half;
    end
  end
`else
  assign w_tick = (r_state != S_OVER) && (r_cnt == CNT_W'(BALL_MOVEMENT_FREQUENCY - 1));
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_phase_nxt      = r_phase;
    w_x_nxt          = r_x;
    w_y_nxt          = r_y;
    w_dx_neg_nxt     = r_dx_neg;
    w_dy_neg_nxt     = r_dy_neg;
    w_srv_dx_neg_nxt = r_srv_dx_neg;
    w_s1_nxt         = r_s1;
    w_s2_nxt         = r_s2;
    if (w_tick) begin
      unique case (r_state)
        S_SERVE: begin
          if (r_phase == SERVE_LAST) begin
            w_phase_nxt = '0;
            w_state_nxt = S_PLAY;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
        S_PLAY: begin
          if ((!r_dy_neg && (w_y_ext >= LIM_MAX_Y)) || (r_dy_neg && (w_y_ext <= LIM_MIN_Y)))
            w_dy_neg_nxt = !r_dy_neg;
          else
            w_y_nxt = r_dy_neg ? r_y - 10'd1 : r_y + 10'd1;

          if (w_t1_hit) begin
            w_dx_neg_nxt = 1'b0;
          end else if (w_t2_hit) begin
            w_dx_neg_nxt = 1'b1;
          end else if (!r_dx_neg && (w_x_ext >= LIM_MAX_X)) begin
            if (w_in_goal) begin
              w_s1_nxt         = r_s1 + 4'd1;
              w_srv_dx_neg_nxt = 1'b1;
              w_phase_nxt      = '0;
              w_state_nxt      = S_GOAL;
            end else begin
              w_dx_neg_nxt = 1'b1;
            end
          end else if (r_dx_neg && (w_x_ext <= LIM_MIN_X)) begin
            if (w_in_goal) begin
              w_s2_nxt         = r_s2 + 4'd1;
              w_srv_dx_neg_nxt = 1'b0;
              w_phase_nxt      = '0;
              w_state_nxt      = S_GOAL;
            end else begin
              w_dx_neg_nxt = 1'b0;
            end
          end else begin
            w_x_nxt = r_dx_neg ? r_x - 10'd1 : r_x + 10'd1;
          end
        end
        S_GOAL: begin
          if (r_phase == GOAL_LAST) begin
            w_phase_nxt = '0;
            if ((r_s1 == WIN) || (r_s2 == WIN)) begin
              w_state_nxt = S_OVER;
            end else begin
              w_x_nxt      = INIT_X;
              w_y_nxt      = INIT_Y;
              w_dy_neg_nxt = 1'b0;
              w_dx_neg_nxt = r_srv_dx_neg;
              w_state_nxt  = S_SERVE;
            end
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_SERVE;
      r_cnt        <= '0;
      r_phase      <= '0;
      r_x          <= INIT_X;
      r_y          <= INIT_Y;
      r_dx_neg     <= 1'b0;
      r_dy_neg     <= 1'b0;
      r_srv_dx_neg <= 1'b0;
      r_s1         <= '0;
      r_s2         <= '0;
      r_goal_flash <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      if (r_state != S_OVER)
        r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_dx_neg     <= w_dx_neg_nxt;
      r_dy_neg     <= w_dy_neg_nxt;
      r_srv_dx_neg <= w_srv_dx_neg_nxt;
      r_s1         <= w_s1_nxt;
      r_s2         <= w_s2_nxt;
      r_goal_flash <= (w_state_nxt == S_GOAL);
      r_game_over  <= (w_state_nxt == S_OVER);
    end
  end

  assign bus.ball_x      = r_x;
  assign bus.ball_y      = r_y;
  assign bus.team1_score = r_s1;
  assign bus.team2_score = r_s2;
  assign bus.goal_flash  = r_goal_flash;
  assign bus.game_over   = r_game_over;

endmodule

// File: tb/tb_quidditch_ball_controller.sv
// Scoreboard bench: five controller instances in different field/goal setups;
// expectations are tagged with the clock count at which they must hold.
module tb_quidditch_ball_controller;

  logic clk;
  logic rst;
  logic rst_r;
  int   cyc;

  typedef struct {
    int cyc;
    int inst;
    int fld;
    int val;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  int   checks;
  int   failures;

  localparam int LAST_CYC = 1330;

  quidditch_ball_controller_if if_main ();
  quidditch_ball_controller_if if_bnc ();
  quidditch_ball_controller_if if_miss ();
  quidditch_ball_controller_if if_over ();
  quidditch_ball_controller_if if_rst ();

  quidditch_ball_controller #(
    .BALL_MOVEMENT_FREQUENCY(4), .SERVE_DELAY(2), .GOAL_HOLD(3)
  ) u_main (.clk(clk), .rst(rst), .bus(if_main));

  quidditch_ball_controller #(
    .BALL_MOVEMENT_FREQUENCY(4), .SERVE_DELAY(2), .GOAL_HOLD(3),
    .FIELD_MIN_Y(290), .FIELD_MAX_Y(310)
  ) u_bnc (.clk(clk), .rst(rst), .bus(if_bnc));

  // Centre 301: with GOAL_RADIUS 0 the ball arrives at y=300, so this is a clean miss
  quidditch_ball_controller #(
    .BALL_MOVEMENT_FREQUENCY(4), .SERVE_DELAY(2), .GOAL_HOLD(3),
    .FIELD_MIN_Y(290), .FIELD_MAX_Y(310), .GOAL_RADIUS(0), .GOAL_CENTER_Y(301)
  ) u_miss (.clk(clk), .rst(rst), .bus(if_miss));

  quidditch_ball_controller #(
    .BALL_MOVEMENT_FREQUENCY(4), .SERVE_DELAY(2), .GOAL_HOLD(3),
    .FIELD_MIN_Y(290), .FIELD_MAX_Y(310), .WIN_SCORE(1)
  ) u_over (.clk(clk), .rst(rst), .bus(if_over));

  quidditch_ball_controller #(
    .BALL_MOVEMENT_FREQUENCY(4), .SERVE_DELAY(2), .GOAL_HOLD(3)
  ) u_rst (.clk(clk), .rst(rst_r), .bus(if_rst));

  assign if_main.team2_ver_position = if_main.ball_y;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fname(input int fld);
    case (fld)
      0: return "ball_x";
      1: return "ball_y";
      2: return "team1_score";
      3: return "team2_score";
      4: return "goal_flash";
      default: return "game_over";
    endcase
  endfunction

  function automatic int get_out(input int inst, input int fld);
    logic [9:0] x, y;
    logic [3:0] a, b;
    logic       f, o;
    x = '0; y = '0; a = '0; b = '0; f = 1'b0; o = 1'b0;
    case (inst)
      0: begin x = if_main.ball_x; y = if_main.ball_y; a = if_main.team1_score;
               b = if_main.team2_score; f = if_main.goal_flash; o = if_main.game_over; end
      1: begin x = if_bnc.ball_x; y = if_bnc.ball_y; a = if_bnc.team1_score;
               b = if_bnc.team2_score; f = if_bnc.goal_flash; o = if_bnc.game_over; end
      2: begin x = if_miss.ball_x; y = if_miss.ball_y; a = if_miss.team1_score;
               b = if_miss.team2_score; f = if_miss.goal_flash; o = if_miss.game_over; end
      3: begin x = if_over.ball_x; y = if_over.ball_y; a = if_over.team1_score;
               b = if_over.team2_score; f = if_over.goal_flash; o = if_over.game_over; end
      default: begin x = if_rst.ball_x; y = if_rst.ball_y; a = if_rst.team1_score;
               b = if_rst.team2_score; f = if_rst.goal_flash; o = if_rst.game_over; end
    endcase
    case (fld)
      0: return int'(x);
      1: return int'(y);
      2: return int'(a);
      3: return int'(b);
      4: return int'(f);
      default: return int'(o);
    endcase
  endfunction

  task automatic push(input int c, input int inst, input int fld, input int val);
    exp_t e;
    e.cyc = c; e.inst = inst; e.fld = fld; e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_xy(input int c, input int inst, input int x, input int y);
    push(c, inst, 0, x);
    push(c, inst, 1, y);
  endtask

  // Stimulus: reset release at time 23, so active edge k lands on cyc 2+k.
  // Ticks fall on every 4th active edge; PLAY starts on the 2nd tick.
  initial begin
    rst   = 1'b1;
    rst_r = 1'b1;
    if_main.team1_ver_position = '0;
    if_bnc.team1_ver_position  = '0;
    if_bnc.team2_ver_position  = '0;
    if_miss.team1_ver_position = '0;
    if_miss.team2_ver_position = '0;
    if_over.team1_ver_position = '0;
    if_over.team2_ver_position = '0;
    if_rst.team1_ver_position  = '0;
    if_rst.team2_ver_position  = '0;

    for (int f = 0; f < 6; f++) push(1, 0, f, (f == 0) ? 500 : (f == 1) ? 300 : 0);
    push_xy(2, 4, 500, 300);

    push_xy(13, 0, 500, 300);
    push_xy(14, 0, 501, 301);
    push_xy(690, 0, 670, 470);
    push(694, 0, 0, 670);
    push(698, 0, 0, 669);
    push(698, 0, 2, 0);
    push(698, 0, 3, 0);

    push(30, 1, 1, 305);
    push(34, 1, 1, 305);
    push(38, 1, 1, 304);
    push(1110, 1, 0, 775);
    push(1110, 1, 2, 0);
    push(1114, 1, 0, 775);
    push(1114, 1, 2, 1);
    push(1114, 1, 4, 1);
    push(1122, 1, 4, 1);
    push(1122, 1, 0, 775);
    push_xy(1126, 1, 500, 300);
    push(1126, 1, 4, 0);
    push(1126, 1, 2, 1);
    push(1134, 1, 0, 500);
    push_xy(1138, 1, 499, 301);

    push(1110, 2, 0, 775);
    push(1114, 2, 0, 775);
    push(1114, 2, 2, 0);
    push(1114, 2, 3, 0);
    push(1114, 2, 4, 0);
    push(1118, 2, 0, 774);

    push(1114, 3, 2, 1);
    push(1114, 3, 4, 1);
    push(1122, 3, 5, 0);
    push(1126, 3, 5, 1);
    push(1126, 3, 4, 0);
    push(1126, 3, 0, 775);
    push(1126, 3, 2, 1);
    for (int j = 1; j <= 5; j++) begin
      push(1126 + 40 * j, 3, 0, 775);
      push(1126 + 40 * j, 3, 2, 1);
      push(1126 + 40 * j, 3, 5, 1);
    end

    push_xy(22, 4, 503, 303);

    #23;
    rst   = 1'b0;
    rst_r = 1'b0;

    #213;
    rst_r = 1'b1;
    push_xy(24, 4, 500, 300);
    push(24, 4, 2, 0);
    push(24, 4, 5, 0);
    #7;
    rst_r = 1'b0;
    push_xy(35, 4, 500, 300);
    push_xy(36, 4, 501, 301);
  end

  initial begin
    checks   = 0;
    failures = 0;
    while (cyc <= LAST_CYC) begin
      @(negedge clk);
      keep = {};
      foreach (sb[i]) begin
        if (sb[i].cyc == cyc) begin
          int act;
          act = get_out(sb[i].inst, sb[i].fld);
          checks++;
          if (act != sb[i].val) begin
            failures++;
            $display("FAIL inst%0d.%s cyc=%0d actual=%0d required=%0d",
                     sb[i].inst, fname(sb[i].fld), cyc, act, sb[i].val);
          end
        end else if (sb[i].cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL inst%0d.%s expired at cyc=%0d required=%0d",
                   sb[i].inst, fname(sb[i].fld), sb[i].cyc, sb[i].val);
        end else begin
          keep.push_back(sb[i]);
        end
      end
      sb = keep;
    end
    foreach (sb[i]) begin
      checks++;
      failures++;
      $display("FAIL inst%0d.%s never sampled cyc=%0d required=%0d",
               sb[i].inst, fname(sb[i].fld), sb[i].cyc, sb[i].val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quidditch_ball_controller.md
Name: quidditch_ball_controller

Overview:
- Owns the ball (quaffle) in the game: a match-sequencing FSM plus the ball-motion datapath.
- Moves the ball on a divided tick, reflects it off field walls and off both team players, detects goals, keeps scores and declares game over.
- Sits beside game_controller on vga_clk. Takes the two team vertical positions and feeds ball position and score to vga_controller for drawing.

Parameters:
- PLAYER_RADIUS, 25, half-height of the player hit zone (pixels)
- BALL_RADIUS, 5, ball half-size
- GOAL_RADIUS, 40, goal half-height around GOAL_CENTER_Y
- GOAL_CENTER_Y, 300, goal vertical centre (both goals)
- TEAM1_HOR_POS, 300, team1 player column
- TEAM2_HOR_POS, 700, team2 player column
- FIELD_MIN_X / FIELD_MAX_X, 20 / 780, horizontal field limits
- FIELD_MIN_Y / FIELD_MAX_Y, 20 / 580, vertical field limits
- INITIAL_BALL_X / INITIAL_BALL_Y, 500 / 300, serve position
- BALL_MOVEMENT_FREQUENCY, 100000, clocks per move tick
- SERVE_DELAY, 64, ticks spent in SERVE
- GOAL_HOLD, 128, ticks spent in GOAL
- WIN_SCORE, 7, score that ends the match (1..15)

Ports:
- clk  in  1  vga_clk domain clock
- rst  in  1  asynchronous, active-high reset
- team1_ver_position  in  10  team1 player centre row
- team2_ver_position  in  10  team2 player centre row
- ball_x  out  10  ball centre column
- ball_y  out  10  ball centre row
- team1_score  out  4  goals scored by team1
- team2_score  out  4  goals scored by team2
- goal_flash  out  1  high while in GOAL
- game_over  out  1  high in OVER

Behaviour:
- Reset values:
  - ball_x = INITIAL_BALL_X, ball_y = INITIAL_BALL_Y
  - dx = +1, dy = +1
  - scores 0, goal_flash 0, game_over 0
  - tick counter 0, state SERVE, serve counter 0
- Tick:
  - Counter runs 0..BALL_MOVEMENT_FREQUENCY-1.
  - tick is a 1-clock pulse on the wrap.
  - The counter free-runs in every state except OVER.
- All state and ball updates occur only on the tick clock. Outputs are registered and visible the clock after the tick.
- SERVE:
  - Ball is held at the initial position.
  - After SERVE_DELAY ticks, go to PLAY.
- PLAY, per tick, axes evaluated independently:
  - Vertical: if dy=+1 and ball_y+BALL_RADIUS >= FIELD_MAX_Y, or dy=-1 and ball_y-BALL_RADIUS <= FIELD_MIN_Y, then negate dy and hold ball_y. Otherwise ball_y += dy.
  - Team1 hit (priority 1): dx=-1 and ball_x == TEAM1_HOR_POS+PLAYER_RADIUS+BALL_RADIUS and |ball_y-team1_ver_position| <= PLAYER_RADIUS+BALL_RADIUS. Set dx=+1 and hold ball_x.
  - Team2 hit (priority 1): dx=+1 and ball_x == TEAM2_HOR_POS-PLAYER_RADIUS-BALL_RADIUS and |ball_y-team2_ver_position| <= PLAYER_RADIUS+BALL_RADIUS. Set dx=-1 and hold ball_x.
  - Right edge (priority 2): dx=+1 and ball_x+BALL_RADIUS >= FIELD_MAX_X.
    - If |ball_y-GOAL_CENTER_Y| <= GOAL_RADIUS: team1_score++, go to GOAL, next serve dx=-1.
    - Otherwise: dx=-1, hold ball_x.
  - Left edge (priority 2): mirror of the right edge at FIELD_MIN_X. On a goal, team2_score++ and next serve dx=+1.
  - Otherwise ball_x += dx.
  - Abs-differences use 11-bit signed arithmetic; no wrap.
- GOAL:
  - goal_flash=1 and ball frozen at the scoring position.
  - After GOAL_HOLD ticks: if either score == WIN_SCORE, go to OVER; else recentre the ball, set dy=+1, go to SERVE.
- OVER:
  - game_over=1, ball and scores frozen, tick counter stopped.
  - Only rst exits.
- Player positions are sampled combinationally on the tick clock; no debounce is done here.
- rst asserted mid-operation immediately forces all reset values, whatever the state.

Optional Feature:
- BALL_SPEEDUP_EN defined:
  - A 2-bit hit counter increments on each player hit.
  - On every 4th hit the tick period halves, down to a floor of BALL_MOVEMENT_FREQUENCY/4.
  - Period and hit counter restore on entry to SERVE and on rst.
- BALL_SPEEDUP_EN undefined: fixed period; no hit counter logic.

Test Plan:
- Common overrides: BALL_MOVEMENT_FREQUENCY=4, SERVE_DELAY=2, GOAL_HOLD=3.
- Reset and serve: release rst -> (500,300), scores 0. PLAY after 8 clocks; next tick -> (501,301).
- Vertical bounce (FIELD_MIN_Y=290, FIELD_MAX_Y=310): ball_y climbs to 305, holds 305 one tick, then 304.
- Team2 hit (team2_ver_position tracks ball_y): at ball_x=670 dx flips; next ball_x 669; scores unchanged.
- Goal (bounce limits as above, team2_ver_position=0):
  - Ball reaches x=775: team1_score=1, goal_flash high 3 ticks.
  - Then (500,300) and the next PLAY tick gives x=499.
- Miss: same as Goal with GOAL_RADIUS=0 -> bounce at x=775, then 774, no score.
- Game over and reset (WIN_SCORE=1):
  - After the first goal plus 3 ticks, game_over=1 and outputs stay frozen for 50 ticks.
  - Pulsing rst mid-PLAY in a fresh run returns reset values on the same edge.
